id_stage_mips32: RTL and testbench

- Instruction Decode stage of the pipelined MIPS32 core, directly downstream of instruction fetch.
- Consumes the IF/ID latch: IF_ID_IR and IF_ID_NPC.
- Owns the 32x32 register bank. Reads operands, sign-extends the immediate and classifies the opcode.
- Loads the ID/EX pipeline register. Also accepts the WB write port, the branch-squash input and the halt-freeze input.

---
 rtl/id_stage_mips32.sv | 148 ++++++++++++++
 tb/tb_id_stage_mips32.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/id_stage_mips32.sv
// Instruction Decode stage of the pipelined MIPS32 core: owns the register bank,
// decodes the IF/ID latch and loads the ID/EX pipeline register on clk2.
module id_stage_mips32 #(
  parameter int          WIDTH    = 32,
  parameter int          RADDR_W  = 5,
  parameter logic [2:0]  NOP_TYPE = 3'b110
) (
  input  logic               clk2,
  input  logic               rst,
  input  logic               halted,
  input  logic               taken_branch,
  input  logic               stall,
  input  logic [WIDTH-1:0]   if_id_ir,
  input  logic [WIDTH-1:0]   if_id_npc,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output logic [WIDTH-1:0]   id_ex_ir,
  output logic [WIDTH-1:0]   id_ex_npc,
  output logic [WIDTH-1:0]   id_ex_a,
  output logic [WIDTH-1:0]   id_ex_b,
  output logic [WIDTH-1:0]   id_ex_imm,
  output logic [2:0]         id_ex_type,
  output logic               id_ex_valid
);

  localparam int NREG = 2 ** RADDR_W;

  localparam logic [2:0] T_RR_ALU = 3'b000;
  localparam logic [2:0] T_RM_ALU = 3'b001;
  localparam logic [2:0] T_LOAD   = 3'b010;
  localparam logic [2:0] T_STORE  = 3'b011;
  localparam logic [2:0] T_BRANCH = 3'b100;
  localparam logic [2:0] T_HALT   = 3'b101;

  function automatic logic [2:0] decode_type(input logic [5:0] opcode);
    logic [2:0] t;
    case (opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101: t = T_RR_ALU;
      6'b001010, 6'b001011, 6'b001100: t = T_RM_ALU;
      6'b001000:                       t = T_LOAD;
      6'b001001:                       t = T_STORE;
      6'b001101, 6'b001110:            t = T_BRANCH;
      6'b111111:                       t = T_HALT;
      default:                         t = NOP_TYPE;
    endcase
    return t;
  endfunction

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];

  logic [WIDTH-1:0] ir_q, ir_d, npc_q, npc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [2:0]       type_q, type_d;
  logic             valid_q, valid_d;

  logic [RADDR_W-1:0] rs_s, rt_s;
  logic               wb_hit_s;
  logic [WIDTH-1:0]   rd_a_s, rd_b_s;

  assign rs_s     = if_id_ir[25:21];
  assign rt_s     = if_id_ir[20:16];
  assign wb_hit_s = wb_we && (wb_addr != {RADDR_W{1'b0}});

  // Operand read with write-through from the WB port; R0 is hardwired to zero.
  always_comb begin
    rd_a_s = {WIDTH{1'b0}};
    rd_b_s = {WIDTH{1'b0}};
    if (rs_s == {RADDR_W{1'b0}}) rd_a_s = {WIDTH{1'b0}};
    else if (wb_hit_s && (wb_addr == rs_s)) rd_a_s = wb_data;
    else rd_a_s = rf_q[rs_s];
    if (rt_s == {RADDR_W{1'b0}}) rd_b_s = {WIDTH{1'b0}};
    else if (wb_hit_s && (wb_addr == rt_s)) rd_b_s = wb_data;
    else rd_b_s = rf_q[rt_s];
  end

  // Register bank update: retirement writes proceed even while halted, stalled or squashing.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit_s) rf_d[wb_addr] = wb_data;
    else rf_d[wb_addr] = rf_q[wb_addr];
  end

  // ID/EX next state: halt freezes, branch squashes (even under stall), stall holds.
  always_comb begin
    ir_d    = ir_q;
    npc_d   = npc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    type_d  = type_q;
    valid_d = valid_q;
    if (halted) begin
      valid_d = valid_q;
    end else if (taken_branch) begin
      ir_d    = {WIDTH{1'b0}};
      npc_d   = {WIDTH{1'b0}};
      a_d     = {WIDTH{1'b0}};
      b_d     = {WIDTH{1'b0}};
      imm_d   = {WIDTH{1'b0}};
      type_d  = NOP_TYPE;
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      ir_d    = if_id_ir;
      npc_d   = if_id_npc;
      a_d     = rd_a_s;
      b_d     = rd_b_s;
      imm_d   = {{(WIDTH-16){if_id_ir[15]}}, if_id_ir[15:0]};
      type_d  = decode_type(if_id_ir[31:26]);
      valid_d = 1'b1;
    end
  end

  // State registers for the bank and the ID/EX latch.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= {WIDTH{1'b0}};
      ir_q    <= {WIDTH{1'b0}};
      npc_q   <= {WIDTH{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      imm_q   <= {WIDTH{1'b0}};
      type_q  <= NOP_TYPE;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      type_q  <= type_d;
      valid_q <= valid_d;
    end
  end

  assign id_ex_ir    = ir_q;
  assign id_ex_npc   = npc_q;
  assign id_ex_a     = a_q;
  assign id_ex_b     = b_q;
  assign id_ex_imm   = imm_q;
  assign id_ex_type  = type_q;
  assign id_ex_valid = valid_q;

endmodule

// File: tb/tb_id_stage_mips32.sv
// Directed, table-driven bench for id_stage_mips32 with hand-computed expectations.
module tb_id_stage_mips32;

  logic        clk2 = 1'b0;
  logic        rst;
  logic        halted, taken_branch, stall;
  logic [31:0] if_id_ir, if_id_npc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] id_ex_ir, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
  logic [2:0]  id_ex_type;
  logic        id_ex_valid;

  int n_cmp = 0;
  int n_bad = 0;

  id_stage_mips32 dut (
    .clk2(clk2), .rst(rst), .halted(halted), .taken_branch(taken_branch), .stall(stall),
    .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .id_ex_ir(id_ex_ir), .id_ex_npc(id_ex_npc), .id_ex_a(id_ex_a),
    .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm), .id_ex_type(id_ex_type), .id_ex_valid(id_ex_valid)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic [31:0] ir, npc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st, br, hl;
    logic [31:0] e_ir, e_npc, e_a, e_b, e_imm;
    logic [2:0]  e_type;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] ir, npc, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic st, br, hl,
                              input logic [31:0] e_ir, e_npc, e_a, e_b, e_imm,
                              input logic [2:0] e_type, input logic e_valid);
    vec_t v;
    v.ir = ir; v.npc = npc; v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.br = br; v.hl = hl;
    v.e_ir = e_ir; v.e_npc = e_npc; v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm;
    v.e_type = e_type; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_ir, e_npc, e_a, e_b, e_imm,
                         input logic [2:0] e_type, input logic e_valid);
    chk({tag, ".ir"},    id_ex_ir,  e_ir);
    chk({tag, ".npc"},   id_ex_npc, e_npc);
    chk({tag, ".a"},     id_ex_a,   e_a);
    chk({tag, ".b"},     id_ex_b,   e_b);
    chk({tag, ".imm"},   id_ex_imm, e_imm);
    chk({tag, ".type"},  {29'd0, id_ex_type},  {29'd0, e_type});
    chk({tag, ".valid"}, {31'd0, id_ex_valid}, {31'd0, e_valid});
  endtask

  task automatic idle_inputs();
    halted = 1'b0; taken_branch = 1'b0; stall = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    // Reset with random inputs: outputs must already be cleared before any edge.
    rst = 1'b1;
    halted = 1'($urandom); taken_branch = 1'($urandom); stall = 1'($urandom);
    if_id_ir = $urandom; if_id_npc = $urandom;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = $urandom;
    #2;
    chk_all("reset_async", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b110, 1'b0);
    repeat (2) @(posedge clk2);
    #1;
    chk_all("reset_held", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b110, 1'b0);
    @(negedge clk2);
    rst = 1'b0;
    idle_inputs();

    //          ir            npc     we   wa     wd            st    br    hl     e_ir          e_npc   e_a           e_b           e_imm         type    v
    vecs.push_back(mk(32'h4000_0000, 32'd1, 1'b1, 5'd1, 32'h0000_000A, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32'd1, 32'd0,        32'd0,        32'd0,        3'b110, 1'b1));
    vecs.push_back(mk(32'h0022_1800, 32'd2, 1'b1, 5'd2, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 32'h0022_1800, 32'd2, 32'h0000_000A, 32'h0000_0014, 32'h0000_1800, 3'b000, 1'b1));
    vecs.push_back(mk(32'h2822_FFFD, 32'd3, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h2822_FFFD, 32'd3, 32'h0000_000A, 32'h0000_0014, 32'hFFFF_FFFD, 3'b001, 1'b1));
    vecs.push_back(mk(32'h2102_0078, 32'd4, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h2102_0078, 32'd4, 32'd0,        32'h0000_0014, 32'h0000_0078, 3'b010, 1'b1));
    vecs.push_back(mk(32'h2400_0005, 32'd5, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h2400_0005, 32'd5, 32'd0,        32'd0,        32'h0000_0005, 3'b011, 1'b1));
    vecs.push_back(mk(32'h3801_0010, 32'd6, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h3801_0010, 32'd6, 32'd0,        32'h0000_000A, 32'h0000_0010, 3'b100, 1'b1));
    vecs.push_back(mk(32'h3420_FFFF, 32'd7, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h3420_FFFF, 32'd7, 32'h0000_000A, 32'd0,        32'hFFFF_FFFF, 3'b100, 1'b1));
    vecs.push_back(mk(32'h00A5_0000, 32'd8, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h00A5_0000, 32'd8, 32'h0000_1234, 32'h0000_1234, 32'd0,        3'b000, 1'b1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(32'h2822_FFFD, 32'd9, 1'b0, 5'd0, 32'd0,      1'b1, 1'b0, 1'b0, 32'h00A5_0000, 32'd8, 32'h0000_1234, 32'h0000_1234, 32'd0,        3'b000, 1'b1));
    vecs.push_back(mk(32'h2822_FFFD, 32'd10, 1'b0, 5'd0, 32'd0,       1'b1, 1'b1, 1'b0, 32'd0,        32'd0, 32'd0,        32'd0,        32'd0,        3'b110, 1'b0));
    vecs.push_back(mk(32'hFC00_0000, 32'h10, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'hFC00_0000, 32'h10, 32'd0,       32'd0,        32'd0,        3'b101, 1'b1));
    vecs.push_back(mk(32'h0080_0000, 32'h11, 1'b1, 5'd4, 32'd7,       1'b0, 1'b0, 1'b1, 32'hFC00_0000, 32'h10, 32'd0,       32'd0,        32'd0,        3'b101, 1'b1));
    vecs.push_back(mk(32'h0080_0000, 32'h11, 1'b0, 5'd0, 32'd0,       1'b0, 1'b1, 1'b1, 32'hFC00_0000, 32'h10, 32'd0,       32'd0,        32'd0,        3'b101, 1'b1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(32'h0080_0000, 32'h11, 1'b0, 5'd0, 32'd0,     1'b1, 1'b0, 1'b1, 32'hFC00_0000, 32'h10, 32'd0,       32'd0,        32'd0,        3'b101, 1'b1));
    vecs.push_back(mk(32'h0080_0000, 32'h11, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'h0080_0000, 32'h11, 32'd7,       32'd0,        32'd0,        3'b000, 1'b1));
    vecs.push_back(mk(32'h1420_0000, 32'h12, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'h1420_0000, 32'h12, 32'h0000_000A, 32'd0,      32'd0,        3'b000, 1'b1));
    vecs.push_back(mk(32'h3000_8000, 32'h13, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'h3000_8000, 32'h13, 32'd0,       32'd0,        32'hFFFF_8000, 3'b001, 1'b1));
    vecs.push_back(mk(32'h2C00_7FFF, 32'h14, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'h2C00_7FFF, 32'h14, 32'd0,       32'd0,        32'h0000_7FFF, 3'b001, 1'b1));
    vecs.push_back(mk(32'hF800_0000, 32'h15, 1'b0, 5'd0, 32'd0,       1'b0, 1'b0, 1'b0, 32'hF800_0000, 32'h15, 32'd0,       32'd0,        32'd0,        3'b110, 1'b1));

    foreach (vecs[i]) begin
      if_id_ir = vecs[i].ir; if_id_npc = vecs[i].npc;
      wb_we = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
      stall = vecs[i].st; taken_branch = vecs[i].br; halted = vecs[i].hl;
      @(posedge clk2);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_npc, vecs[i].e_a,
              vecs[i].e_b, vecs[i].e_imm, vecs[i].e_type, vecs[i].e_valid);
      @(negedge clk2);
    end
    idle_inputs();

    // Mid-operation reset clears outputs without a clock edge and wipes the bank (R5 was 0x1234).
    rst = 1'b1;
    #1;
    chk_all("midreset", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b110, 1'b0);
    @(negedge clk2);
    rst = 1'b0;
    if_id_ir = 32'h00A0_0000; if_id_npc = 32'h20;
    @(posedge clk2);
    #1;
    chk_all("post_reset_r5", 32'h00A0_0000, 32'h20, 32'd0, 32'd0, 32'd0, 3'b000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
